// File: rtl/conv_window_mac.sv
// Window MAC consumer for the row-buffer loader: requests one FILTER_SIZE-row band per
// output row, slides the kernel across it and streams signed results on valid/ready.
module conv_window_mac #(
  parameter int IMAGE_WIDTH  = 9,
  parameter int IMAGE_HEIGHT = 9,
  parameter int FILTER_SIZE  = 3,
  parameter int ACC_W        = 20
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [FILTER_SIZE*FILTER_SIZE*8-1:0]     kernel_flat,
  input  logic [FILTER_SIZE*IMAGE_WIDTH*8-1:0]     row_buffer_flat,
  input  logic                                     loaded,
  output logic                                     new_buffer,
  output logic signed [ACC_W-1:0]                  out_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [$clog2(IMAGE_HEIGHT):0]            out_row,
  output logic [$clog2(IMAGE_WIDTH):0]             out_col,
  output logic                                     busy,
  output logic                                     done
);

  localparam int OUT_H  = IMAGE_HEIGHT - FILTER_SIZE + 1;
  localparam int OUT_W  = IMAGE_WIDTH - FILTER_SIZE + 1;
  localparam int ROW_W  = $clog2(IMAGE_HEIGHT) + 1;
  localparam int COL_W  = $clog2(IMAGE_WIDTH) + 1;
  localparam int BAND_W = FILTER_SIZE * IMAGE_WIDTH * 8;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUT_H - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUT_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_COMPUTE, S_DRAIN, S_FIN
  } state_t;

  state_t                   state_q, state_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [BAND_W-1:0]        band_q, band_d;
  logic signed [ACC_W-1:0]  data_q, data_d;
  logic                     valid_q, valid_d;
  logic [ROW_W-1:0]         orow_q, orow_d;
  logic [COL_W-1:0]         ocol_q, ocol_d;

  logic signed [ACC_W-1:0]  win_sum;
  logic signed [8:0]        pix;
  logic signed [7:0]        coef;
  logic signed [16:0]       prod;
  logic                     accept;

  // Pixels are unsigned, so they get a zero sign bit before the signed multiply.
  always_comb begin
    win_sum = '0;
    pix     = '0;
    coef    = '0;
    prod    = '0;
    for (int unsigned i = 0; i < FILTER_SIZE; i++) begin
      for (int unsigned j = 0; j < FILTER_SIZE; j++) begin
        pix     = {1'b0, band_q[(i*IMAGE_WIDTH + j + 32'(col_q))*8 +: 8]};
        coef    = kernel_flat[(i*FILTER_SIZE + j)*8 +: 8];
        prod    = 17'(pix) * 17'(coef);
        win_sum = win_sum + ACC_W'(prod);
      end
    end
  end

  assign accept = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    band_d  = band_q;
    data_d  = data_q;
    valid_d = valid_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    if (accept) valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (loaded) begin
          band_d  = row_buffer_flat;
          col_d   = '0;
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (!valid_q || out_ready) begin
          data_d  = win_sum;
          orow_d  = row_q;
          ocol_d  = col_q;
          valid_d = 1'b1;
          if (col_q == LAST_COL) state_d = S_DRAIN;
          else                   col_d   = col_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (accept) begin
          if (row_q != LAST_ROW) begin
            row_d   = row_q + 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        row_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      band_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      orow_q  <= '0;
      ocol_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      band_q  <= band_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
    end
  end

  assign new_buffer = (state_q == S_REQ);
  assign done       = (state_q == S_FIN);
  assign busy       = state_q inside {S_REQ, S_WAIT, S_COMPUTE, S_DRAIN};
  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign out_row    = orow_q;
  assign out_col    = ocol_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac: behavioural loader, reference convolution model
// feeding an expected-result queue, and handshake/stability checks on the output stream.
module tb_conv_window_mac;

  localparam int W   = 9;
  localparam int H   = 9;
  localparam int F   = 3;
  localparam int ACC = 20;
  localparam int OH  = H - F + 1;
  localparam int OW  = W - F + 1;
  localparam int RW  = $clog2(H) + 1;
  localparam int CW  = $clog2(W) + 1;

  typedef struct packed {
    logic [RW-1:0]         r;
    logic [CW-1:0]         c;
    logic signed [ACC-1:0] d;
  } res_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [F*F*8-1:0]        kernel_flat;
  logic [F*W*8-1:0]        row_buffer_flat;
  logic                    loaded;
  logic                    new_buffer;
  logic signed [ACC-1:0]   out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [RW-1:0]           out_row;
  logic [CW-1:0]           out_col;
  logic                    busy;
  logic                    done;

  always #5 clk = ~clk;

  conv_window_mac #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .FILTER_SIZE (F),
    .ACC_W       (ACC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .kernel_flat    (kernel_flat),
    .row_buffer_flat(row_buffer_flat),
    .loaded         (loaded),
    .new_buffer     (new_buffer),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_row        (out_row),
    .out_col        (out_col),
    .busy           (busy),
    .done           (done)
  );

  logic [7:0]        img  [H][W];
  logic signed [7:0] kern [F][F];
  res_t              exp_q[$];
  res_t              held;
  int n_assert = 0, n_fail = 0;
  int cyc = 0, nb_cnt = 0, done_cnt = 0, acc_cnt = 0, last_acc_cyc = 0, done_cyc = 0, ptr = 0;
  bit nb_pend = 0, ld_now = 0, hold = 0, rnd_ready = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_image(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (mode == 0) ? 8'(r*W + c) : 8'd255;
  endtask

  task automatic set_kernel(input int mode, input logic signed [7:0] v);
    for (int i = 0; i < F; i++)
      for (int j = 0; j < F; j++) begin
        if (mode == 0) kern[i][j] = v;
        else           kern[i][j] = (i == F/2 && j == F/2) ? 8'sd1 : 8'sd0;
        kernel_flat[(i*F + j)*8 +: 8] = kern[i][j];
      end
  endtask

  task automatic push_expected();
    res_t e;
    int   s;
    exp_q.delete();
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++) begin
        s = 0;
        for (int i = 0; i < F; i++)
          for (int j = 0; j < F; j++)
            s += int'(img[r+i][c+j]) * int'(kern[i][j]);
        e.r = RW'(r);
        e.c = CW'(c);
        e.d = ACC'(s);
        exp_q.push_back(e);
      end
  endtask

  // One clock: observe at the falling edge, drive just after the rising edge.
  task automatic tick();
    res_t got, e;
    @(negedge clk);
    if (!rst) begin
      ptr = 0; nb_pend = 0; hold = 0;
    end else begin
      if (hold) chk("hold_stable", {out_valid, out_row, out_col, out_data}, {1'b1, held});
      if (out_valid && out_ready) begin
        got = {out_row, out_col, out_data};
        if (exp_q.size() == 0) chk("extra_result", 64'(exp_q.size()), 64'd1);
        else begin
          e = exp_q.pop_front();
          chk("result", got, e);
        end
        acc_cnt++;
        last_acc_cyc = cyc;
      end
      hold = out_valid && !out_ready;
      held = {out_row, out_col, out_data};
      if (new_buffer) begin nb_cnt++; nb_pend = 1; end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
    cyc++;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (ld_now) begin loaded = 1'b0; ld_now = 0; end
    if (nb_pend) begin
      for (int i = 0; i < F; i++)
        for (int j = 0; j < W; j++)
          row_buffer_flat[(i*W + j)*8 +: 8] = img[ptr+i][j];
      loaded = 1'b1; ld_now = 1; nb_pend = 0;
      ptr = (ptr == OH-1) ? 0 : ptr + 1;
    end
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run_frame(input string tag, input bit rand_rdy, input bit poke_start);
    nb_cnt = 0; done_cnt = 0; acc_cnt = 0;
    push_expected();
    rnd_ready = rand_rdy;
    start = 1'b1;
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      tick();
      if (poke_start && k == 40) start = 1'b1;
    end
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_new_buffer_pulses"}, 64'(nb_cnt), 64'(OH));
    chk({tag, "_accepted"}, 64'(acc_cnt), 64'(OH*OW));
    chk({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_done_latency"}, 64'(done_cyc - last_acc_cyc), 64'd1);
    chk({tag, "_busy_after_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; loaded = 1'b0; out_ready = 1'b0;
    kernel_flat = '0; row_buffer_flat = '0;
    repeat (3) tick();
    chk("reset_state", {out_data, out_valid, out_row, out_col, new_buffer, busy, done}, '0);
    rst = 1'b1;
    tick();

    set_image(0); set_kernel(0, 8'sd1);
    run_frame("ones", 0, 1);
    set_kernel(1, 8'sd0);
    run_frame("identity", 0, 0);
    set_image(1); set_kernel(0, -8'sd128);
    run_frame("neg_max", 0, 0);
    set_kernel(0, 8'sd127);
    run_frame("pos_max", 0, 0);
    set_image(0); set_kernel(0, 8'sd1);
    run_frame("backpressure", 1, 0);

    nb_cnt = 0; done_cnt = 0; acc_cnt = 0; rnd_ready = 0;
    push_expected();
    start = 1'b1;
    for (int k = 0; k < 500 && acc_cnt < 20; k++) tick();
    chk("abort_reached_20", 64'(acc_cnt), 64'd20);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("outputs_in_reset", {out_data, out_valid, out_row, out_col, new_buffer, busy, done}, '0);
    end
    chk("no_done_on_abort", 64'(done_cnt), 64'd0);
    rst = 1'b1;
    tick();
    run_frame("after_reset", 0, 0);

    run_frame("b2b_first", 0, 0);
    run_frame("b2b_second", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
